seq_detector_1011: RTL

SEQ_DETECTOR_1011 -- requirements
Module: seq_detector_1011

---
 rtl/seq_det_pkg.sv | 15 +
 rtl/seq_detector_1011_sat_counter.sv | 39 +++
 rtl/seq_detector_1011.sv | 73 +++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants for the 1011 serial pattern detector.
// State codes, pattern and default counter width.
package seq_det_pkg;

  localparam int unsigned CNT_W_DEF = 8;

  localparam logic [3:0] PATTERN = 4'b1011;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_1    = 3'd1;
  localparam logic [2:0] S_10   = 3'd2;
  localparam logic [2:0] S_101  = 3'd3;
  localparam logic [2:0] S_1011 = 3'd4;

endpackage

// File: rtl/seq_detector_1011_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Reset and clear both take priority over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: clear first, then saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector_1011.sv
// Overlapping 1011 serial detector with match pulse.
// Saturating match counter kept in sat_counter.
module seq_detector_1011
  import seq_det_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  input  logic             clr_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic [2:0]       state_o
);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       match_q;
  logic       match_d;

  // next state; held whenever en is low
  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        S_IDLE:
          state_d = (din == PATTERN[3]) ? S_1 : S_IDLE;
        S_1:
          state_d = (din == PATTERN[2]) ? S_10 : S_1;
        S_10:
          state_d = (din == PATTERN[1]) ? S_101 : S_IDLE;
        S_101:
          state_d = (din == PATTERN[0]) ? S_1011 : S_10;
        S_1011:
          state_d = din ? S_1 : S_10;
        default:
          state_d = S_IDLE;
      endcase
    end
  end

  // S_1011 cannot re-enter itself, so this is a single pulse
  always_comb begin
    match_d = en && (state_d == S_1011);
  end

  // state and match registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (match_d),
    .clr (clr_cnt),
    .cnt (match_cnt)
  );

  assign match   = match_q;
  assign state_o = state_q;

endmodule
